// File: rtl/mips_seq_pkg.sv
// Shared types and constants for the multi-cycle MIPS control sequencer.
package mips_seq_pkg;

  localparam int SEQ_STATE_W = 3;
  localparam int PERF_W      = 32;

  typedef enum logic [SEQ_STATE_W-1:0] {
    ST_FETCH    = 3'd0,
    ST_DECODE   = 3'd1,
    ST_EXEC     = 3'd2,
    ST_ALU_WAIT = 3'd3,
    ST_MEM      = 3'd4,
    ST_WB       = 3'd5,
    ST_HALT     = 3'd6
  } seq_state_t;

endpackage

// File: rtl/seq_wait_timer.sv
// Saturating wait counter shared by the FETCH, MEM and ALU_WAIT handshakes.
// expire fires in the waiting cycle whose increment would reach WAIT_MAX.
module seq_wait_timer #(
  parameter int WAIT_MAX = 255
) (
  input  logic clk,
  input  logic rst_b,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [CW:0] LIMIT = (CW + 1)'(WAIT_MAX);

  logic [CW-1:0] count;
  logic [CW:0]   count_inc;

  assign count_inc = {1'b0, count} + (CW + 1)'(1);
  assign expire    = en && (count_inc >= LIMIT);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count_inc <= LIMIT)) begin
      count <= count_inc[CW-1:0];
    end
  end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/write-back sequencer for the MIPS core.
// Optional CORE_SEQ_PERF_EN adds perf_cycles / perf_instrs counters.
module core_sequencer
  import mips_seq_pkg::*;
#(
  parameter int WAIT_MAX = 255
) (
  input  logic                   clk,
  input  logic                   rst_b,
  input  logic                   cu_mem_read,
  input  logic                   cu_mem_write,
  input  logic                   cu_reg_write,
  input  logic                   cu_jump,
  input  logic                   cu_branch,
  input  logic                   cu_halted,
  input  logic                   cu_multicycle,
  input  logic                   alu_done,
  input  logic                   mem_ready,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic                   mem_sel_data,
  output logic                   ir_write,
  output logic                   pc_write,
  output logic                   alu_start,
  output logic                   reg_write,
  output logic                   halted,
  output logic                   timeout_err,
`ifdef CORE_SEQ_PERF_EN
  output logic [PERF_W-1:0]      perf_cycles,
  output logic [PERF_W-1:0]      perf_instrs,
`endif
  output logic [SEQ_STATE_W-1:0] state
);

  seq_state_t st;
  logic       halted_q;
  logic       timeout_q;
  logic       waiting;
  logic       done;
  logic       expire;

  // Jumps and branches share the EXEC fall-through path, so their bits are not needed here.
  logic unused_ctrl;
  assign unused_ctrl = cu_jump ^ cu_branch;

  always_comb begin
    waiting = (st == ST_FETCH) || (st == ST_MEM) || (st == ST_ALU_WAIT);
    done    = (((st == ST_FETCH) || (st == ST_MEM)) && mem_ready) ||
              ((st == ST_ALU_WAIT) && alu_done);
  end

  seq_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_timer (
    .clk    (clk),
    .rst_b  (rst_b),
    .clr    (!waiting || done),
    .en     (waiting && !done),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      st        <= ST_FETCH;
      halted_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      case (st)
        ST_FETCH: begin
          if (mem_ready) begin
            st <= ST_DECODE;
          end else if (expire) begin
            st        <= ST_HALT;
            halted_q  <= 1'b1;
            timeout_q <= 1'b1;
          end
        end
        ST_DECODE: begin
          if (cu_halted) begin
            st       <= ST_HALT;
            halted_q <= 1'b1;
          end else begin
            st <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (cu_multicycle)                   st <= ST_ALU_WAIT;
          else if (cu_mem_read || cu_mem_write) st <= ST_MEM;
          else if (cu_reg_write)               st <= ST_WB;
          else                                 st <= ST_FETCH;
        end
        ST_ALU_WAIT: begin
          if (alu_done) begin
            st <= ST_WB;
          end else if (expire) begin
            st        <= ST_HALT;
            halted_q  <= 1'b1;
            timeout_q <= 1'b1;
          end
        end
        ST_MEM: begin
          if (mem_ready) begin
            st <= cu_mem_read ? ST_WB : ST_FETCH;
          end else if (expire) begin
            st        <= ST_HALT;
            halted_q  <= 1'b1;
            timeout_q <= 1'b1;
          end
        end
        ST_WB: st <= ST_FETCH;
        default: begin
          st       <= ST_HALT;
          halted_q <= 1'b1;
        end
      endcase
    end
  end

  // Outputs are gated by rst_b so an in-flight request drops as soon as reset asserts.
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_sel_data = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    alu_start    = 1'b0;
    reg_write    = 1'b0;
    if (rst_b) begin
      case (st)
        ST_FETCH: begin
          mem_req  = 1'b1;
          ir_write = mem_ready;
        end
        ST_EXEC: begin
          alu_start = cu_multicycle;
          pc_write  = !cu_multicycle && !cu_mem_read && !cu_mem_write && !cu_reg_write;
        end
        ST_MEM: begin
          mem_req      = 1'b1;
          mem_sel_data = 1'b1;
          mem_we       = cu_mem_write;
          pc_write     = mem_ready && !cu_mem_read;
        end
        ST_WB: begin
          reg_write = 1'b1;
          pc_write  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state       = st;
  assign halted      = halted_q;
  assign timeout_err = timeout_q;

`ifdef CORE_SEQ_PERF_EN
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      perf_cycles <= '0;
      perf_instrs <= '0;
    end else begin
      if (st != ST_HALT) perf_cycles <= perf_cycles + 1'b1;
      if (pc_write)      perf_instrs <= perf_instrs + 1'b1;
    end
  end
`endif

endmodule
